// File: rtl/afifo_wr_packer.sv
// Write-side packer for the async FIFO: assembles IN_W-bit beats LSB-lane-first into
// WIDTH-bit words and feeds them through a 2-entry queue to the FIFO write port.
module afifo_wr_packer #(
  parameter int unsigned     WIDTH = 16,
  parameter int unsigned     IN_W  = 8,
  parameter logic [IN_W-1:0] PAD   = '0
) (
  input  logic             wclk_i,
  input  logic             wrst_n_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [IN_W-1:0]  s_data_i,
  input  logic             s_last_i,
  output logic             wen_o,
  output logic [WIDTH-1:0] wdata_o,
  input  logic             wfull_i,
  output logic             partial_o,
  output logic [15:0]      wr_words_o
);

  localparam int unsigned    RATIO    = WIDTH / IN_W;
  localparam int unsigned    LW       = $clog2(RATIO);
  localparam logic [LW-1:0]  LastLane = LW'(RATIO - 1);

  logic [LW-1:0]    lane_q, lane_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic [1:0]       cnt_q, cnt_d;
  logic [15:0]      wr_words_q;
  logic             accept, complete, pop;

  // Ready depends only on registered occupancy, so upstream timing never sees wfull_i.
  assign s_ready_o  = (cnt_q != 2'd2);
  assign wen_o      = (cnt_q != 2'd0) && !wfull_i;
  assign pop        = wen_o;
  assign wdata_o    = mem_q[0];
  assign partial_o  = (lane_q != '0);
  assign wr_words_o = wr_words_q;

  assign accept   = s_valid_i && s_ready_o;
  assign complete = accept && ((lane_q == LastLane) || s_last_i);

  // Completed word: lanes below the current one from assembly, current from input,
  // lanes above padded.
  always_comb begin
    word = asm_q;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (i == 32'(lane_q)) begin
        word[i*IN_W +: IN_W] = s_data_i;
      end else if (i > 32'(lane_q)) begin
        word[i*IN_W +: IN_W] = PAD;
      end
    end
  end

  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    if (accept) begin
      if (complete) begin
        lane_d = '0;
        asm_d  = '0;
      end else begin
        lane_d = lane_q + 1'b1;
        asm_d[32'(lane_q)*IN_W +: IN_W] = s_data_i;
      end
    end
  end

  // Pop shifts the queue first; a push then lands at the post-pop tail, preserving order.
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    cnt_d    = cnt_q;
    if (pop) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = '0;
      cnt_d    = cnt_q - 2'd1;
    end
    if (complete) begin
      mem_d[cnt_d[0]] = word;
      cnt_d           = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      lane_q     <= '0;
      asm_q      <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      cnt_q      <= 2'd0;
      wr_words_q <= 16'd0;
    end else begin
      lane_q   <= lane_d;
      asm_q    <= asm_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      cnt_q    <= cnt_d;
      if (wen_o) begin
        wr_words_q <= wr_words_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_afifo_wr_packer.sv
// Directed bench for afifo_wr_packer: default 16/8 instance plus a 32/8 PAD=0xA5 instance.
module tb_afifo_wr_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, wfull = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, wen, partial;
  logic [15:0] wdata, wr_words;

  logic        s2_valid = 1'b0, s2_last = 1'b0, wfull2 = 1'b0;
  logic [7:0]  s2_data = '0;
  logic        s2_ready, wen2, partial2;
  logic [31:0] wdata2;
  logic [15:0] wr_words2;

  int n_checks = 0;
  int n_pass = 0;
  logic [15:0] got[$];
  bit mon_en = 1'b1;

  always #5 clk = ~clk;

  afifo_wr_packer #(.WIDTH(16), .IN_W(8), .PAD(8'h00)) dut (
    .wclk_i(clk), .wrst_n_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .s_last_i(s_last), .wen_o(wen), .wdata_o(wdata),
    .wfull_i(wfull), .partial_o(partial), .wr_words_o(wr_words)
  );

  afifo_wr_packer #(.WIDTH(32), .IN_W(8), .PAD(8'hA5)) dut2 (
    .wclk_i(clk), .wrst_n_i(rst_n), .s_valid_i(s2_valid), .s_ready_o(s2_ready),
    .s_data_i(s2_data), .s_last_i(s2_last), .wen_o(wen2), .wdata_o(wdata2),
    .wfull_i(wfull2), .partial_o(partial2), .wr_words_o(wr_words2)
  );

  // Each cycle has one negedge, so a word written at the next posedge is logged once.
  always @(negedge clk) begin
    if (mon_en && rst_n && wen) got.push_back(wdata);
  end

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; wfull = 1'b0;
    s2_valid = 1'b0; s2_last = 1'b0; s2_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit done = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: beat %h not accepted, required acceptance within 50 cycles", d);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", s_ready); else n_pass++;
    n_checks++; if (wen !== 1'b0) $display("FAIL reset_wen: got %b want 0", wen); else n_pass++;
    n_checks++; if (wdata !== 16'h0) $display("FAIL reset_wdata: got %h want 0000", wdata); else n_pass++;
    n_checks++; if (partial !== 1'b0) $display("FAIL reset_partial: got %b want 0", partial); else n_pass++;
    n_checks++; if (wr_words !== 16'h0) $display("FAIL reset_words: got %h want 0000", wr_words); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    send(8'h11, 1'b0);
    n_checks++; if (partial !== 1'b1) $display("FAIL stream_partial_mid: got %b want 1", partial); else n_pass++;
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (got.size() !== 2) $display("FAIL stream_count: got %0d words want 2", got.size()); else n_pass++;
    if (got.size() == 2) begin
      n_checks++; if (got[0] !== 16'h2211) $display("FAIL stream_w0: got %h want 2211", got[0]); else n_pass++;
      n_checks++; if (got[1] !== 16'h4433) $display("FAIL stream_w1: got %h want 4433", got[1]); else n_pass++;
    end
    n_checks++; if (wr_words !== 16'd2) $display("FAIL stream_words: got %0d want 2", wr_words); else n_pass++;
    n_checks++; if (partial !== 1'b0) $display("FAIL stream_partial_end: got %b want 0", partial); else n_pass++;
  endtask

  task automatic test_partial();
    do_reset();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (got.size() !== 2) $display("FAIL partial_count: got %0d words want 2", got.size()); else n_pass++;
    if (got.size() == 2) begin
      n_checks++; if (got[1] !== 16'h0033) $display("FAIL partial_pad0: got %h want 0033", got[1]); else n_pass++;
    end
    // Wide instance: a single beat with last pads three lanes with 0xA5.
    @(posedge clk);
    #1 s2_valid = 1'b1; s2_data = 8'h01; s2_last = 1'b1;
    @(posedge clk);
    #1 s2_valid = 1'b0; s2_last = 1'b0;
    @(negedge clk);
    n_checks++; if (wen2 !== 1'b1) $display("FAIL pad_wen: got %b want 1", wen2); else n_pass++;
    n_checks++; if (wdata2 !== 32'hA5A5A501) $display("FAIL pad_word: got %h want a5a5a501", wdata2); else n_pass++;
  endtask

  task automatic test_backpressure();
    int  acc = 0;
    bit  wen_seen = 1'b0, stable = 1'b1, hold, done = 1'b0;
    logic [7:0] d = 8'h01;
    do_reset();
    wfull = 1'b1; s_valid = 1'b1; s_data = d; s_last = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (wen) wen_seen = 1'b1;
      if (acc >= 2 && wdata !== 16'h0201) stable = 1'b0;
      hold = s_ready;
      @(posedge clk);
      #1;
      if (hold) begin acc++; d = d + 8'd1; s_data = d; end
    end
    n_checks++; if (acc !== 4) $display("FAIL bp_accepted: got %0d beats want 4", acc); else n_pass++;
    n_checks++; if (wen_seen !== 1'b0) $display("FAIL bp_wen: got wen high while full, want 0"); else n_pass++;
    n_checks++; if (stable !== 1'b1 || wdata !== 16'h0201) $display("FAIL bp_stable: got %h want 0201 stable", wdata); else n_pass++;
    n_checks++; if (s_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", s_ready); else n_pass++;
    wfull = 1'b0;
    @(negedge clk);
    n_checks++; if (wen !== 1'b1 || s_ready !== 1'b0) $display("FAIL bp_release: got wen=%b ready=%b want wen=1 ready=0", wen, s_ready); else n_pass++;
    @(posedge clk);
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      hold = s_ready;
      @(posedge clk);
      #1;
      if (hold) begin
        if (d == 8'h10) begin done = 1'b1; s_valid = 1'b0; end
        else begin d = d + 8'd1; s_data = d; end
      end
    end
    n_checks++; if (!done) $display("FAIL bp_drain_timeout: got last beat %h, want 10 accepted", d); else n_pass++;
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (got.size() !== 8) $display("FAIL bp_count: got %0d words want 8", got.size()); else n_pass++;
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      logic [15:0] exp;
      exp = {8'(2*k + 2), 8'(2*k + 1)};
      n_checks++; if (got[k] !== exp) $display("FAIL bp_word%0d: got %h want %h", k, got[k], exp); else n_pass++;
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    wfull = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    s_data = 8'h44; s_last = 1'b1; s_valid = 1'b1; wfull = 1'b0;
    @(negedge clk);
    n_checks++; if (wen !== 1'b1 || wdata !== 16'h2211) $display("FAIL pp_before: got wen=%b data=%h want 1/2211", wen, wdata); else n_pass++;
    @(posedge clk);
    #1 s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    n_checks++; if (wen !== 1'b1 || wdata !== 16'h4433) $display("FAIL pp_after: got wen=%b data=%h want 1/4433", wen, wdata); else n_pass++;
    n_checks++; if (s_ready !== 1'b1) $display("FAIL pp_ready: got %b want 1 (one entry held)", s_ready); else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (got.size() !== 2 || wr_words !== 16'd2) $display("FAIL pp_count: got %0d words cnt %0d want 2/2", got.size(), wr_words); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 wfull = 1'b1;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    s_valid = 1'b0;
    #2 rst_n = 1'b0; wfull = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b1 || wen !== 1'b0) $display("FAIL rstmid_ctl: got ready=%b wen=%b want 1/0", s_ready, wen); else n_pass++;
    n_checks++; if (wdata !== 16'h0 || partial !== 1'b0) $display("FAIL rstmid_data: got data=%h partial=%b want 0000/0", wdata, partial); else n_pass++;
    n_checks++; if (wr_words !== 16'h0) $display("FAIL rstmid_words: got %h want 0000", wr_words); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    got.delete();
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (got.size() < 1 || got[0] !== 16'h6655) $display("FAIL rstmid_first: got %0d words head %h want 6655", got.size(), (got.size() > 0) ? got[0] : 16'hxxxx); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    mon_en = 1'b0;
    s_valid = 1'b1; s_last = 1'b1; s_data = 8'h5A;
    repeat (65535) @(posedge clk);
    #1 s_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (wr_words !== 16'hFFFF) $display("FAIL wrap_ffff: got %h want ffff", wr_words); else n_pass++;
    @(posedge clk);
    #1 s_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (wr_words !== 16'h0001) $display("FAIL wrap_0001: got %h want 0001", wr_words); else n_pass++;
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_partial();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
